// File: rtl/costas_hop_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : costas_hop_sequencer_if
//  Description : Control, table-load and DDS-side signal bundle for the
//                Costas hop sequencer.
//                master = controller / DDS side, slave = sequencer side.
//  Signals     : pps, costas_txrq, abort, repeat_en, base_ftw, step_ftw,
//                dwell_cycles, perm_we/addr/data   (master -> slave)
//                ftw, fq_ud, hop_idx, busy, done, cfg_err (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface costas_hop_sequencer_if #(
    parameter int IDX_W   = 3,
    parameter int FTW_W   = 32,
    parameter int DWELL_W = 24
);
    logic               pps;
    logic               costas_txrq;
    logic               abort;
    logic               repeat_en;
    logic [FTW_W-1:0]   base_ftw;
    logic [FTW_W-1:0]   step_ftw;
    logic [DWELL_W-1:0] dwell_cycles;
    logic               perm_we;
    logic [IDX_W-1:0]   perm_addr;
    logic [IDX_W-1:0]   perm_data;

    logic [FTW_W-1:0]   ftw;
    logic               fq_ud;
    logic [IDX_W-1:0]   hop_idx;
    logic               busy;
    logic               done;
    logic               cfg_err;

    modport master (
        output pps, costas_txrq, abort, repeat_en, base_ftw, step_ftw,
               dwell_cycles, perm_we, perm_addr, perm_data,
        input  ftw, fq_ud, hop_idx, busy, done, cfg_err
    );

    modport slave (
        input  pps, costas_txrq, abort, repeat_en, base_ftw, step_ftw,
               dwell_cycles, perm_we, perm_addr, perm_data,
        output ftw, fq_ud, hop_idx, busy, done, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/costas_hop_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : costas_hop_sequencer
//  Description : Costas-array frequency-hop sequencer for the DDS front end.
//                Walks an N_HOPS-entry run-time-loadable permutation table,
//                one hop per dwell period of D cycles, producing the DDS
//                tuning word ftw = base + perm[hop]*step and an fq_ud strobe
//                of UPD_W cycles that rises one cycle after ftw settles.
//                Start is immediate or PPS aligned; single-shot or repeat.
//  Ports       : sys_clk  - system clock
//                rst_n    - asynchronous active-low reset
//                hop_if   - slave side of costas_hop_sequencer_if
//                           (start/abort/repeat, tuning config, table write,
//                            ftw/fq_ud/hop_idx/busy/done/cfg_err outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module costas_hop_sequencer #(
    parameter int N_HOPS    = 7,
    parameter int FTW_W     = 32,
    parameter int DWELL_W   = 24,
    parameter int UPD_W     = 4,
    parameter int PPS_ALIGN = 1
) (
    input  wire logic             sys_clk,
    input  wire logic             rst_n,
    costas_hop_sequencer_if.slave hop_if
);

    localparam int                 IDX_W         = (N_HOPS > 1) ? $clog2(N_HOPS) : 1;
    // Shortest legal hop: LOAD + UPD_W strobe cycles + at least one dwell cycle.
    localparam logic [DWELL_W-1:0] C_MIN_DWELL   = DWELL_W'(UPD_W + 2);
    localparam logic [DWELL_W-1:0] C_STROBE_LAST = DWELL_W'(UPD_W - 1);
    localparam logic [IDX_W-1:0]   C_LAST_HOP    = IDX_W'(N_HOPS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STROBE = 3'd3,
        ST_DWELL  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    state_t             state_q,     state_d;
    logic [DWELL_W-1:0] cnt_q,       cnt_d;
    logic [DWELL_W-1:0] dwell_q,     dwell_d;
    logic [FTW_W-1:0]   base_q,      base_d;
    logic [FTW_W-1:0]   step_q,      step_d;
    logic [FTW_W-1:0]   ftw_q,       ftw_d;
    logic               fq_ud_q,     fq_ud_d;
    logic [IDX_W-1:0]   hop_idx_q,   hop_idx_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               cfg_err_q,   cfg_err_d;
    logic               pps_meta_q,  pps_meta_d;
    logic               pps_sync_q,  pps_sync_d;
    logic               pps_prev_q,  pps_prev_d;
    logic [IDX_W-1:0]   perm_q [N_HOPS];
    logic [IDX_W-1:0]   perm_d [N_HOPS];

    logic               w_pps_rise;
    logic               w_wr_ok;
    logic [FTW_W-1:0]   w_hop_ftw;

    assign w_pps_rise = pps_sync_q & ~pps_prev_q;

    // Range checks done in 32 bits so a power-of-two N_HOPS cannot wrap.
    assign w_wr_ok = (state_q == ST_IDLE)
                   && (32'(hop_if.perm_addr) < N_HOPS)
                   && (32'(hop_if.perm_data) < N_HOPS);

    // IDX_W x FTW_W product, low FTW_W bits kept; the sum wraps mod 2^FTW_W.
    assign w_hop_ftw = base_q + FTW_W'(perm_q[hop_idx_q]) * step_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dwell_d    = dwell_q;
        base_d     = base_q;
        step_d     = step_q;
        ftw_d      = ftw_q;
        hop_idx_d  = hop_idx_q;
        done_d     = 1'b0;
        cfg_err_d  = cfg_err_q;
        perm_d     = perm_q;
        pps_meta_d = hop_if.pps;
        pps_sync_d = pps_meta_q;
        pps_prev_d = pps_sync_q;
        // Strobe is the STROBE state delayed by one cycle, so fq_ud rises
        // one cycle after the ftw update at the LOAD exit edge.
        fq_ud_d    = (state_q == ST_STROBE);

        if (hop_if.perm_we) begin
            if (w_wr_ok) begin
                perm_d[hop_if.perm_addr] = hop_if.perm_data;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (hop_if.costas_txrq) begin
                    dwell_d = hop_if.dwell_cycles;
                    base_d  = hop_if.base_ftw;
                    step_d  = hop_if.step_ftw;
                    if (hop_if.dwell_cycles < C_MIN_DWELL) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = (PPS_ALIGN != 0) ? ST_ARM : ST_LOAD;
                    end
                end
            end
            ST_ARM: begin
                if (w_pps_rise) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ftw_d   = w_hop_ftw;
                cnt_d   = C_STROBE_LAST;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    // Remaining dwell = D - 1 (LOAD) - UPD_W cycles.
                    cnt_d   = dwell_q - C_MIN_DWELL;
                    state_d = ST_DWELL;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            ST_DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (hop_idx_q != C_LAST_HOP) begin
                    hop_idx_d = hop_idx_q + IDX_W'(1);
                    state_d   = ST_LOAD;
                end else if (hop_if.repeat_en) begin
                    hop_idx_d = '0;
                    state_d   = ST_LOAD;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // Occupies the slot where the next LOAD would be, so done
                // lands exactly one dwell period after the last ftw update.
                done_d    = 1'b1;
                hop_idx_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (hop_if.abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            fq_ud_d   = 1'b0;
            hop_idx_d = '0;
            done_d    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dwell_q    <= '0;
            base_q     <= '0;
            step_q     <= '0;
            ftw_q      <= '0;
            fq_ud_q    <= 1'b0;
            hop_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            pps_meta_q <= 1'b0;
            pps_sync_q <= 1'b0;
            pps_prev_q <= 1'b0;
            for (int i = 0; i < N_HOPS; i++) begin
                perm_q[i] <= IDX_W'(i);
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dwell_q    <= dwell_d;
            base_q     <= base_d;
            step_q     <= step_d;
            ftw_q      <= ftw_d;
            fq_ud_q    <= fq_ud_d;
            hop_idx_q  <= hop_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            pps_meta_q <= pps_meta_d;
            pps_sync_q <= pps_sync_d;
            pps_prev_q <= pps_prev_d;
            perm_q     <= perm_d;
        end
    end

    assign hop_if.ftw     = ftw_q;
    assign hop_if.fq_ud   = fq_ud_q;
    assign hop_if.hop_idx = hop_idx_q;
    assign hop_if.busy    = busy_q;
    assign hop_if.done    = done_q;
    assign hop_if.cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_costas_hop_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_costas_hop_sequencer
//  Description : Directed self-checking bench. dut0: N_HOPS=6, immediate
//                start. dut1: N_HOPS=6, PPS aligned start. UPD_W=4, D=20.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_costas_hop_sequencer;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    costas_hop_sequencer_if #(.IDX_W(3), .FTW_W(32), .DWELL_W(24)) if0 ();
    costas_hop_sequencer_if #(.IDX_W(3), .FTW_W(32), .DWELL_W(24)) if1 ();

    costas_hop_sequencer #(
        .N_HOPS(6), .FTW_W(32), .DWELL_W(24), .UPD_W(4), .PPS_ALIGN(0)
    ) dut0 (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .hop_if  (if0)
    );

    costas_hop_sequencer #(
        .N_HOPS(6), .FTW_W(32), .DWELL_W(24), .UPD_W(4), .PPS_ALIGN(1)
    ) dut1 (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .hop_if  (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1);
    end

    // Recorded activity of dut0 during a capture window.
    logic [31:0] ch_val [$];
    int          ch_cyc [$];
    int          fq_rise[$];
    int          fq_len [$];
    int          done_cyc[$];
    int          exp_seq [6] = '{1200, 1100, 1500, 1300, 1400, 1000};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr0(input logic [2:0] a, input logic [2:0] d);
        if0.perm_we   = 1'b1;
        if0.perm_addr = a;
        if0.perm_data = d;
        @(negedge clk);
        if0.perm_we   = 1'b0;
    endtask

    task automatic start0();
        if0.costas_txrq = 1'b1;
        @(negedge clk);
        if0.costas_txrq = 1'b0;
    endtask

    task automatic abort0();
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
    endtask

    task automatic capture0(input int ncyc, input int clr_after);
        logic [31:0] prev_ftw;
        logic        prev_fq;
        ch_val.delete(); ch_cyc.delete(); fq_rise.delete(); fq_len.delete(); done_cyc.delete();
        prev_ftw = if0.ftw;
        prev_fq  = if0.fq_ud;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (if0.ftw !== prev_ftw) begin
                ch_val.push_back(if0.ftw);
                ch_cyc.push_back(cyc);
            end
            if (if0.fq_ud === 1'b1 && prev_fq !== 1'b1) begin
                fq_rise.push_back(cyc);
                fq_len.push_back(0);
            end
            if (if0.fq_ud === 1'b1 && fq_len.size() > 0)
                fq_len[fq_len.size()-1] = fq_len[fq_len.size()-1] + 1;
            if (if0.done === 1'b1) done_cyc.push_back(cyc);
            if (ch_val.size() >= clr_after) if0.repeat_en = 1'b0;
            prev_ftw = if0.ftw;
            prev_fq  = if0.fq_ud;
        end
    endtask

    task automatic check_seq(input string tag, input int nh);
        int n;
        check({tag, "_n_updates"}, ch_val.size(), nh);
        n = (ch_val.size() < nh) ? ch_val.size() : nh;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ftw%0d", tag, i), ch_val[i], exp_seq[i % 6]);
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), ch_cyc[i] - ch_cyc[i-1], 20);
            if (i < fq_rise.size()) begin
                check($sformatf("%s_fqrise%0d", tag, i), fq_rise[i] - ch_cyc[i], 1);
                check($sformatf("%s_fqlen%0d", tag, i), fq_len[i], 4);
            end
        end
        check({tag, "_n_strobes"}, fq_rise.size(), nh);
        check({tag, "_n_done"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0 && n > 0)
            check({tag, "_done_lat"}, done_cyc[0] - ch_cyc[n-1], 20);
        check({tag, "_busy_end"}, if0.busy, 1'b0);
    endtask

    initial begin
        int c0;
        int lat;
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        if0.pps = 1'b0; if0.costas_txrq = 1'b0; if0.abort = 1'b0; if0.repeat_en = 1'b0;
        if0.base_ftw = 32'd1000; if0.step_ftw = 32'd100; if0.dwell_cycles = 24'd20;
        if0.perm_we = 1'b0; if0.perm_addr = 3'd0; if0.perm_data = 3'd0;
        if1.pps = 1'b0; if1.costas_txrq = 1'b0; if1.abort = 1'b0; if1.repeat_en = 1'b0;
        if1.base_ftw = 32'd1000; if1.step_ftw = 32'd100; if1.dwell_cycles = 24'd20;
        if1.perm_we = 1'b0; if1.perm_addr = 3'd0; if1.perm_data = 3'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ftw", if0.ftw, 0);
        check("rst_fq_ud", if0.fq_ud, 0);
        check("rst_hop_idx", if0.hop_idx, 0);
        check("rst_busy", if0.busy, 0);
        check("rst_done", if0.done, 0);
        check("rst_cfg_err", if0.cfg_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-shot sequence with loaded permutation
        wr0(3'd0, 3'd2); wr0(3'd1, 3'd1); wr0(3'd2, 3'd5);
        wr0(3'd3, 3'd3); wr0(3'd4, 3'd4); wr0(3'd5, 3'd0);
        check("wr_cfg_err", if0.cfg_err, 0);
        start0();
        check("start_busy", if0.busy, 1);
        capture0(140, 0);
        check_seq("single", 6);

        // Repeat: two full sequences, repeat cleared after hop 6 starts
        if0.repeat_en = 1'b1;
        start0();
        capture0(260, 7);
        check_seq("repeat", 12);

        // Abort during STROBE of hop 3
        start0();
        for (int i = 0; i < 200 && if0.ftw !== 32'd1300; i++) @(negedge clk);
        check("abort_reach_hop3", if0.ftw, 1300);
        check("abort_pre_hop_idx", if0.hop_idx, 3);
        abort0();
        check("abort_fq_ud", if0.fq_ud, 0);
        check("abort_busy", if0.busy, 0);
        check("abort_hop_idx", if0.hop_idx, 0);
        check("abort_ftw_hold", if0.ftw, 1300);
        check("abort_done", if0.done, 0);
        start0();
        @(negedge clk);
        check("restart_ftw", if0.ftw, 1200);
        check("restart_hop_idx", if0.hop_idx, 0);
        abort0();
        check("restart_abort_busy", if0.busy, 0);

        // PPS aligned start, phase A: pps set at a negedge 50 cycles after txrq
        if1.costas_txrq = 1'b1;
        @(negedge clk);
        if1.costas_txrq = 1'b0;
        check("pps_busy_c1", if1.busy, 1);
        check("pps_ftw_hold", if1.ftw, 0);
        repeat (49) @(negedge clk);
        check("pps_wait_ftw", if1.ftw, 0);
        if1.pps = 1'b1;
        c0 = cyc;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (if1.ftw !== 32'd0) begin lat = cyc - c0; break; end
            @(negedge clk);
        end
        check("pps_lat_phaseA", lat, 4);
        check("pps_ftw_phaseA", if1.ftw, 1000);
        if1.abort = 1'b1;
        @(negedge clk);
        if1.abort = 1'b0;
        if1.pps = 1'b0;
        repeat (5) @(negedge clk);

        // Phase B: pps set 2 ns after a rising edge
        if1.base_ftw = 32'd2000;
        if1.costas_txrq = 1'b1;
        @(negedge clk);
        if1.costas_txrq = 1'b0;
        repeat (23) @(negedge clk);
        @(posedge clk);
        #2;
        if1.pps = 1'b1;
        c0 = cyc;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if1.ftw !== 32'd1000) begin lat = cyc - c0; break; end
        end
        check("pps_lat_phaseB", lat, 4);
        check("pps_ftw_phaseB", if1.ftw, 2000);
        if1.abort = 1'b1;
        @(negedge clk);
        if1.abort = 1'b0;
        if1.pps = 1'b0;

        // Wrap arithmetic, then asynchronous reset mid-sequence
        do_reset();
        wr0(3'd0, 3'd3);
        if0.base_ftw = 32'hFFFF_FF00;
        if0.step_ftw = 32'h0000_0080;
        start0();
        @(negedge clk);
        check("wrap_ftw", if0.ftw, 32'h0000_0080);
        rst_n = 1'b0;
        #1;
        check("midrst_ftw", if0.ftw, 0);
        check("midrst_busy", if0.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if0.base_ftw = 32'd1000;
        if0.step_ftw = 32'd100;

        // Dwell too short: D = 5 < UPD_W+2
        if0.dwell_cycles = 24'd5;
        start0();
        check("shortD_cfg_err", if0.cfg_err, 1);
        check("shortD_busy", if0.busy, 0);
        @(negedge clk);
        check("shortD_idle", if0.busy, 0);
        check("shortD_done", if0.done, 0);

        // Boundary: D = UPD_W+2 is accepted
        do_reset();
        if0.dwell_cycles = 24'd6;
        start0();
        check("minD_busy", if0.busy, 1);
        check("minD_cfg_err", if0.cfg_err, 0);
        abort0();
        if0.dwell_cycles = 24'd20;

        // Out-of-range table data
        do_reset();
        wr0(3'd0, 3'd6);
        check("baddata_cfg_err", if0.cfg_err, 1);
        check("baddata_busy", if0.busy, 0);
        start0();
        @(negedge clk);
        check("baddata_ignored_ftw", if0.ftw, 1000);
        abort0();

        // Table write while busy
        do_reset();
        start0();
        @(negedge clk);
        wr0(3'd0, 3'd5);
        check("busywr_cfg_err", if0.cfg_err, 1);
        check("busywr_busy", if0.busy, 1);
        abort0();
        check("busywr_abort_busy", if0.busy, 0);
        if0.base_ftw = 32'd3000;
        start0();
        @(negedge clk);
        check("busywr_ignored_ftw", if0.ftw, 3000);
        abort0();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
